// File: rtl/fetch_unit.sv
// fetch_unit: two-wide in-order instruction fetch stage.
// Holds the PC and issues two word-aligned reads per cycle to a dual-port
// synchronous instruction memory (1-cycle latency). Presents the returned
// bundle with its PCs to decode. Supports stall (bundle held in local
// registers) and redirect (flush, then restart fetch at the target).
// Optional feature: define FETCH_PERF_EN to add the perf_bundles counter port.
module fetch_unit #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fetch_en,
   input  logic                   stall,
   input  logic                   redirect_en,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc,
   output logic [1:0]             if_valid,
   output logic [ADDR_WIDTH-1:0]  if_pc [1:0],
   output logic [INSTR_WIDTH-1:0] if_instr [1:0],
   output logic [ADDR_WIDTH-1:0]  imem_addr0,
   output logic [ADDR_WIDTH-1:0]  imem_addr1,
   output logic                   imem_ren,
   input  logic [INSTR_WIDTH-1:0] imem_rdata0,
   input  logic [INSTR_WIDTH-1:0] imem_rdata1
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]            perf_bundles
`endif
);

   localparam logic [ADDR_WIDTH-1:0] WordBytes  = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] BundleBytes = ADDR_WIDTH'(8);
   localparam logic [ADDR_WIDTH-1:0] AlignMask  = ~ADDR_WIDTH'(3);

   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic                   pending_valid_q, pending_valid_d;
   logic [ADDR_WIDTH-1:0]  pending_pc_q, pending_pc_d;
   logic                   hold_valid_q, hold_valid_d;
   logic [INSTR_WIDTH-1:0] hold_instr0_q, hold_instr0_d;
   logic [INSTR_WIDTH-1:0] hold_instr1_q, hold_instr1_d;

   logic [ADDR_WIDTH-1:0]  base;
   logic                   issue;

   // Address mux and issue decision; redirect target wins over the sequential PC.
   always_comb begin
      base       = redirect_en ? (redirect_pc & AlignMask) : pc_q;
      issue      = fetch_en & ~stall & ~reset;
      imem_ren   = issue;
      imem_addr0 = base;
      imem_addr1 = base + WordBytes;
   end

   // Next-state for PC, pending request and stall hold registers.
   always_comb begin
      pc_d            = pc_q;
      pending_valid_d = pending_valid_q;
      pending_pc_d    = pending_pc_q;
      hold_valid_d    = hold_valid_q;
      hold_instr0_d   = hold_instr0_q;
      hold_instr1_d   = hold_instr1_q;

      if (issue) begin
         pc_d = base + BundleBytes;
      end else if (redirect_en) begin
         pc_d = base;
      end

      if (issue) begin
         // Either the current bundle is consumed this edge or nothing was shown.
         pending_valid_d = 1'b1;
         pending_pc_d    = base;
         hold_valid_d    = 1'b0;
      end else if (redirect_en || !stall) begin
         // Flush, or consumed without a follow-on request.
         pending_valid_d = 1'b0;
         hold_valid_d    = 1'b0;
      end else if (pending_valid_q && !hold_valid_q) begin
         // First stalled cycle: memory data is live now, capture it.
         hold_valid_d  = 1'b1;
         hold_instr0_d = imem_rdata0;
         hold_instr1_d = imem_rdata1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q            <= RESET_PC;
         pending_valid_q <= 1'b0;
         pending_pc_q    <= '0;
         hold_valid_q    <= 1'b0;
         hold_instr0_q   <= '0;
         hold_instr1_q   <= '0;
      end else begin
         pc_q            <= pc_d;
         pending_valid_q <= pending_valid_d;
         pending_pc_q    <= pending_pc_d;
         hold_valid_q    <= hold_valid_d;
         hold_instr0_q   <= hold_instr0_d;
         hold_instr1_q   <= hold_instr1_d;
      end
   end

   // Bundle outputs; invalid slots read as zero, redirect masks the current bundle.
   always_comb begin
      if_valid    = (pending_valid_q && !redirect_en) ? 2'b11 : 2'b00;
      if_pc[0]    = '0;
      if_pc[1]    = '0;
      if_instr[0] = '0;
      if_instr[1] = '0;
      if (if_valid[0]) begin
         if_pc[0]    = pending_pc_q;
         if_pc[1]    = pending_pc_q + WordBytes;
         if_instr[0] = hold_valid_q ? hold_instr0_q : imem_rdata0;
         if_instr[1] = hold_valid_q ? hold_instr1_q : imem_rdata1;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_q, perf_d;

   // Count bundles handed to decode.
   always_comb begin
      perf_d = perf_q;
      if ((if_valid != 2'b00) && !stall) perf_d = perf_q + 32'd1;
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) perf_q <= '0;
      else       perf_q <= perf_d;
   end

   assign perf_bundles = perf_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector bench for fetch_unit with a small
// synchronous dual-port instruction memory model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic        stall;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic [1:0]  if_valid;
   logic [31:0] if_pc [1:0];
   logic [31:0] if_instr [1:0];
   logic [31:0] imem_addr0;
   logic [31:0] imem_addr1;
   logic        imem_ren;
   logic [31:0] imem_rdata0;
   logic [31:0] imem_rdata1;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_bundles;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mem [16];

   fetch_unit #(
      .ADDR_WIDTH (32),
      .INSTR_WIDTH(32),
      .RESET_PC   (32'h0)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .fetch_en   (fetch_en),
      .stall      (stall),
      .redirect_en(redirect_en),
      .redirect_pc(redirect_pc),
      .if_valid   (if_valid),
      .if_pc      (if_pc),
      .if_instr   (if_instr),
      .imem_addr0 (imem_addr0),
      .imem_addr1 (imem_addr1),
      .imem_ren   (imem_ren),
      .imem_rdata0(imem_rdata0),
      .imem_rdata1(imem_rdata1)
`ifdef FETCH_PERF_EN
      ,
      .perf_bundles(perf_bundles)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous memory: data appears one cycle after ren, holds otherwise.
   always_ff @(posedge clk) begin
      if (imem_ren) begin
         imem_rdata0 <= mem[imem_addr0[5:2]];
         imem_rdata1 <= mem[imem_addr1[5:2]];
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle, drive inputs at the falling edge, settle.
   task automatic cyc(input logic rst, input logic fe, input logic st,
                      input logic re, input logic [31:0] rpc);
      @(negedge clk);
      reset       = rst;
      fetch_en    = fe;
      stall       = st;
      redirect_en = re;
      redirect_pc = rpc;
      #1;
   endtask

   task automatic check_bundle(input string tag, input logic [31:0] pc0,
                               input logic [31:0] i0, input logic [31:0] i1);
      check_eq({tag, "_valid"}, 64'(if_valid), 64'h3);
      check_eq({tag, "_pc0"}, 64'(if_pc[0]), 64'(pc0));
      check_eq({tag, "_pc1"}, 64'(if_pc[1]), 64'(pc0 + 32'd4));
      check_eq({tag, "_i0"}, 64'(if_instr[0]), 64'(i0));
      check_eq({tag, "_i1"}, 64'(if_instr[1]), 64'(i1));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[0]  = 32'h11111111;
      mem[1]  = 32'h22222222;
      mem[2]  = 32'h33333333;
      mem[3]  = 32'h44444444;
      mem[4]  = 32'h55555555;
      mem[5]  = 32'h66666666;
      mem[6]  = 32'h77777777;
      mem[7]  = 32'h88888888;
      mem[15] = 32'hDEADBEEF;
      imem_rdata0 = '0;
      imem_rdata1 = '0;
      reset = 1'b1; fetch_en = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;

      // Reset held for two cycles
      cyc(1, 1, 0, 0, 0);
      check_eq("rst_ren", 64'(imem_ren), 64'h0);
      cyc(1, 1, 0, 0, 0);
      check_eq("rst_valid", 64'(if_valid), 64'h0);
      check_eq("rst_pc0", 64'(if_pc[0]), 64'h0);
      check_eq("rst_instr0", 64'(if_instr[0]), 64'h0);
      check_eq("rst_ren2", 64'(imem_ren), 64'h0);

      // C1: first issue
      cyc(0, 1, 0, 0, 0);
      check_eq("c1_addr0", 64'(imem_addr0), 64'h0);
      check_eq("c1_addr1", 64'(imem_addr1), 64'h4);
      check_eq("c1_ren", 64'(imem_ren), 64'h1);
      check_eq("c1_valid", 64'(if_valid), 64'h0);

      // C2: bundle 0x0
      cyc(0, 1, 0, 0, 0);
      check_bundle("c2", 32'h0, 32'h11111111, 32'h22222222);
      check_eq("c2_addr0", 64'(imem_addr0), 64'h8);

      // C3, C4: stall while 0x8 shown
      cyc(0, 1, 1, 0, 0);
      check_bundle("c3", 32'h8, 32'h33333333, 32'h44444444);
      check_eq("c3_ren", 64'(imem_ren), 64'h0);
      cyc(0, 1, 1, 0, 0);
      check_bundle("c4", 32'h8, 32'h33333333, 32'h44444444);
      check_eq("c4_ren", 64'(imem_ren), 64'h0);

      // C5: release, bundle still shown and consumed this edge
      cyc(0, 1, 0, 0, 0);
      check_bundle("c5", 32'h8, 32'h33333333, 32'h44444444);
      check_eq("c5_ren", 64'(imem_ren), 64'h1);
      check_eq("c5_addr0", 64'(imem_addr0), 64'h10);

      // C6: next bundle one cycle after its issue
      cyc(0, 1, 0, 0, 0);
      check_bundle("c6", 32'h10, 32'h55555555, 32'h66666666);
      check_eq("c6_addr0", 64'(imem_addr0), 64'h18);

      // C7: unaligned redirect to 0x0A while 0x18 shown
      cyc(0, 1, 0, 1, 32'h0000000A);
      check_eq("c7_valid", 64'(if_valid), 64'h0);
      check_eq("c7_pc0", 64'(if_pc[0]), 64'h0);
      check_eq("c7_addr0", 64'(imem_addr0), 64'h8);
      check_eq("c7_addr1", 64'(imem_addr1), 64'hC);
      check_eq("c7_ren", 64'(imem_ren), 64'h1);

      // C8, C9: target stream with no bubble
      cyc(0, 1, 0, 0, 0);
      check_bundle("c8", 32'h8, 32'h33333333, 32'h44444444);
      check_eq("c8_addr0", 64'(imem_addr0), 64'h10);

      // C9: bundle 0x10 shown, redirect to 0x8 with stall
      cyc(0, 1, 1, 1, 32'h00000008);
      check_eq("c9_valid", 64'(if_valid), 64'h0);
      check_eq("c9_ren", 64'(imem_ren), 64'h0);

      // C10: still stalled, nothing pending, pc parked at 0x8
      cyc(0, 1, 1, 0, 0);
      check_eq("c10_valid", 64'(if_valid), 64'h0);
      check_eq("c10_addr0", 64'(imem_addr0), 64'h8);

      // C11: stall drops, target issued
      cyc(0, 1, 0, 0, 0);
      check_eq("c11_valid", 64'(if_valid), 64'h0);
      check_eq("c11_ren", 64'(imem_ren), 64'h1);
      check_eq("c11_addr0", 64'(imem_addr0), 64'h8);

      // C12: bundle 0x8, fetch disabled
      cyc(0, 0, 0, 0, 0);
      check_bundle("c12", 32'h8, 32'h33333333, 32'h44444444);
      check_eq("c12_ren", 64'(imem_ren), 64'h0);

      // C13: drained; redirect to wrap boundary
      cyc(0, 1, 0, 1, 32'hFFFFFFFC);
      check_eq("c13_valid", 64'(if_valid), 64'h0);
      check_eq("c13_addr0", 64'(imem_addr0), 64'hFFFFFFFC);
      check_eq("c13_addr1", 64'(imem_addr1), 64'h0);

      // C14: wrapped bundle, next pc 0x4
      cyc(0, 0, 0, 0, 0);
      check_eq("c14_valid", 64'(if_valid), 64'h3);
      check_eq("c14_pc0", 64'(if_pc[0]), 64'hFFFFFFFC);
      check_eq("c14_pc1", 64'(if_pc[1]), 64'h0);
      check_eq("c14_i0", 64'(if_instr[0]), 64'hDEADBEEF);
      check_eq("c14_i1", 64'(if_instr[1]), 64'h11111111);
      check_eq("c14_addr0", 64'(imem_addr0), 64'h4);

      // C15: idle
      cyc(0, 0, 0, 0, 0);
      check_eq("c15_valid", 64'(if_valid), 64'h0);
`ifdef FETCH_PERF_EN
      // Consumed at C2, C5, C6, C8, C12, C14
      check_eq("perf", 64'(perf_bundles), 64'd6);
`endif

      // Reset mid-operation discards in-flight data
      cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      check_eq("mrst_ren", 64'(imem_ren), 64'h0);
      cyc(0, 1, 0, 0, 0);
      check_eq("mrst_valid", 64'(if_valid), 64'h0);
      check_eq("mrst_addr0", 64'(imem_addr0), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
